// File: rtl/alu_operand_collector_pkg.sv
// Shared types and helpers for the ALU operand collector.
// op_need maps a command to the operands it consumes ({B,A}).
package alu_operand_collector_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_N       = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [DEF_N-1:0] {
    ADD     = 4'd0,
    SUB     = 4'd1,
    ADD_CIN = 4'd2,
    SUB_CIN = 4'd3,
    INC_A   = 4'd4,
    DEC_A   = 4'd5,
    INC_B   = 4'd6,
    DEC_B   = 4'd7,
    CMP     = 4'd8,
    MUL_INC = 4'd9,
    MUL_SHL = 4'd10,
    ADD_SGN = 4'd11,
    ROL     = 4'd12,
    ROR     = 4'd13
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_A,
    WAIT_B,
    ISSUE
  } coll_state_t;

  function automatic logic [1:0] op_need(
    input logic [DEF_N-1:0] cmd,
    input logic             mode
  );
    logic [1:0] n;
    n = 2'b11;
    unique case (1'b1)
      mode && (cmd == 4'd4 || cmd == 4'd5):
        n = 2'b01;
      mode && (cmd == 4'd6 || cmd == 4'd7):
        n = 2'b10;
      !mode && (cmd == 4'd6 || cmd == 4'd8 ||
                cmd == 4'd9):
        n = 2'b01;
      !mode && (cmd == 4'd7 || cmd == 4'd10 ||
                cmd == 4'd11):
        n = 2'b10;
      default:
        n = 2'b11;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/coll_timeout_ctr.sv
// Wait-cycle counter for the operand collector.
// Saturates at TIMEOUT-1 and flags the terminal count.
module coll_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic RST,
  input  logic CE,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (CE) begin
      if (clr)
        count <= '0;
      else if (inc && !term)
        count <= count + 1'b1;
    end
  end

  assign term = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_operand_collector.sv
// Collects A/B operands and command fields for the ALU.
// Waits a bounded number of CE cycles for a missing operand.
module alu_operand_collector
  import alu_operand_collector_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int N       = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         CE,
  input  logic [W-1:0] opa_in,
  input  logic         opa_vld,
  output logic         opa_rdy,
  input  logic [W-1:0] opb_in,
  input  logic         opb_vld,
  output logic         opb_rdy,
  input  logic [N-1:0] cmd_in,
  input  logic         mode_in,
  input  logic         cin_in,
  output logic [W-1:0] OPA,
  output logic [W-1:0] OPB,
  output logic [N-1:0] CMD,
  output logic         mode,
  output logic         Cin,
  output logic [1:0]   inp_valid,
  output logic         busy,
  output logic         timeout_err
);

  coll_state_t state, state_d;
  logic        a_x, b_x;
  logic [1:0]  need_d, rcv;
  logic [1:0]  vld_d;
  logic        tmo_d;
  logic        waiting, term;

  assign a_x     = opa_vld && opa_rdy;
  assign b_x     = opb_vld && opb_rdy;
  assign rcv     = {b_x, a_x};
  assign need_d  = op_need(cmd_in, mode_in);
  assign waiting = (state == WAIT_A) ||
                   (state == WAIT_B);

  coll_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk  (clk),
    .RST  (RST),
    .CE   (CE),
    .clr  (!waiting),
    .inc  (waiting),
    .term (term)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST)
      state <= IDLE;
    else if (CE)
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    vld_d   = inp_valid;
    tmo_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_x || b_x) begin
          vld_d = rcv & need_d;
          if ((rcv & need_d) == need_d)
            state_d = ISSUE;
          else if (need_d[0] && !rcv[0])
            state_d = WAIT_A;
          else
            state_d = WAIT_B;
        end
      end
      WAIT_A, WAIT_B: begin
        if (a_x || b_x) begin
          state_d = ISSUE;
          vld_d   = 2'b11;
        end else if (term) begin
          // abandon so the ALU's own timeout agrees
          state_d = IDLE;
          vld_d   = 2'b00;
          tmo_d   = 1'b1;
        end
      end
      ISSUE: begin
        state_d = IDLE;
        vld_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 2'b00;
      end
    endcase
  end

  always_comb begin
    opa_rdy = 1'b0;
    opb_rdy = 1'b0;
    if (CE && !RST) begin
      unique case (state)
        IDLE: begin
          opa_rdy = 1'b1;
          opb_rdy = 1'b1;
        end
        WAIT_A:  opa_rdy = 1'b1;
        WAIT_B:  opb_rdy = 1'b1;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      OPA         <= '0;
      OPB         <= '0;
      CMD         <= '0;
      mode        <= 1'b0;
      Cin         <= 1'b0;
      inp_valid   <= 2'b00;
      timeout_err <= 1'b0;
    end else if (CE) begin
      inp_valid   <= vld_d;
      timeout_err <= tmo_d;
      if (a_x)
        OPA <= opa_in;
      if (b_x)
        OPB <= opb_in;
      if (state == IDLE && (a_x || b_x)) begin
        CMD  <= cmd_in;
        mode <= mode_in;
        Cin  <= cin_in;
      end
    end
  end

endmodule
